// File: rtl/fifo_sync_param_if.sv
// Handshake and status bundle for fifo_sync_param.
// master = producer/consumer side, slave = FIFO side.
interface fifo_sync_param_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_SIZE  = 3
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic                  err_clr;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  data_valid;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [ADDR_SIZE:0]    fill_level;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, data_in, pop, err_clr,
        input  data_out, data_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );

    modport slave (
        input  push, data_in, pop, err_clr,
        output data_out, data_valid, full, empty, almost_full, almost_empty,
               fill_level, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO: the standard elastic buffer between link-layer
// producers and transaction-layer consumers, with level flags and sticky errors.
module fifo_sync_param #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_SIZE  = 3,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter int RD_LATENCY = 0
) (
    input  logic              clk,
    input  logic              rst,
    fifo_sync_param_if.slave  bus
);
    localparam int LW = ADDR_SIZE + 1;

    if (DEPTH != (1 << ADDR_SIZE)) begin : g_bad_depth
        $fatal(1, "fifo_sync_param: DEPTH must equal 2**ADDR_SIZE");
    end
    if (!(AE_THRESH < AF_THRESH) || (AF_THRESH > DEPTH)) begin : g_bad_thresh
        $fatal(1, "fifo_sync_param: need AE_THRESH < AF_THRESH <= DEPTH");
    end
    if ((RD_LATENCY != 0) && (RD_LATENCY != 1)) begin : g_bad_lat
        $fatal(1, "fifo_sync_param: RD_LATENCY must be 0 or 1");
    end

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_SIZE-1:0]  wr_ptr;
    logic [ADDR_SIZE-1:0]  rd_ptr;
    logic [LW-1:0]         fill_level;
    logic                  overflow;
    logic                  underflow;
    logic                  full;
    logic                  empty;
    logic                  wr_ok;
    logic                  rd_ok;

    assign full  = (fill_level == LW'(DEPTH));
    assign empty = (fill_level == '0);
    assign wr_ok = bus.push & ~full;
    assign rd_ok = bus.pop  & ~empty;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values of wr_ok/rd_ok consistently.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fill_level <= '0;
            overflow   <= 1'b0;
            underflow  <= 1'b0;
        end else begin
            if (wr_ok) wr_ptr <= wr_ptr + ADDR_SIZE'(1);
            if (rd_ok) rd_ptr <= rd_ptr + ADDR_SIZE'(1);
            case ({wr_ok, rd_ok})
                2'b10:   fill_level <= fill_level + LW'(1);
                2'b01:   fill_level <= fill_level - LW'(1);
                default: fill_level <= fill_level;
            endcase
            // A new error in the same cycle as err_clr wins over the clear.
            overflow  <= (bus.push & full)  | (overflow  & ~bus.err_clr);
            underflow <= (bus.pop  & empty) | (underflow & ~bus.err_clr);
        end
    end

    // NOTE: the storage array is reset entry by entry so that a reset
    // mid-stream leaves no stale words behind; this costs a reset per flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_ok) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    if (RD_LATENCY == 0) begin : g_rd_comb
        assign bus.data_out   = (rst && rd_ok) ? mem[rd_ptr] : '0;
        assign bus.data_valid = rst & rd_ok;
    end else begin : g_rd_reg
        logic [DATA_WIDTH-1:0] data_q;
        logic                  valid_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                data_q  <= '0;
                valid_q <= 1'b0;
            end else begin
                data_q  <= rd_ok ? mem[rd_ptr] : '0;
                valid_q <= rd_ok;
            end
        end

        assign bus.data_out   = data_q;
        assign bus.data_valid = valid_q;
    end

    // Flags decode the registered fill level only, so they cannot glitch
    // with push/pop during the cycle.
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (fill_level >= LW'(AF_THRESH));
    assign bus.almost_empty = (fill_level <= LW'(AE_THRESH));
    assign bus.fill_level   = fill_level;
    assign bus.overflow     = overflow;
    assign bus.underflow    = underflow;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Bench for fifo_sync_param: drives a combinational-read and a registered-read
// instance with identical stimulus and checks both against a queue model.
module tb_fifo_sync_param;
    localparam int DW    = 10;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AF    = 6;
    localparam int AE    = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus0 ();
    fifo_sync_param_if #(.DATA_WIDTH(DW), .ADDR_SIZE(AW)) bus1 ();

    fifo_sync_param #(
        .DATA_WIDTH(DW), .ADDR_SIZE(AW), .DEPTH(DEPTH),
        .AF_THRESH(AF), .AE_THRESH(AE), .RD_LATENCY(0)
    ) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    fifo_sync_param #(
        .DATA_WIDTH(DW), .ADDR_SIZE(AW), .DEPTH(DEPTH),
        .AF_THRESH(AF), .AE_THRESH(AE), .RD_LATENCY(1)
    ) dut1 (.clk(clk), .rst(rst), .bus(bus1));

    int n_asserts = 0;
    int n_fail    = 0;

    // Reference model: contents as a queue, plus sticky errors and the
    // registered-port output pair.
    logic [DW-1:0] q [$];
    bit            m_ov;
    bit            m_uf;
    logic [DW-1:0] m_l1_data;
    bit            m_l1_valid;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit p, input logic [DW-1:0] d, input bit r, input bit c, input bit rs);
        rst          = rs;
        bus0.push    = p;  bus1.push    = p;
        bus0.data_in = d;  bus1.data_in = d;
        bus0.pop     = r;  bus1.pop     = r;
        bus0.err_clr = c;  bus1.err_clr = c;
    endtask

    // One clock: apply inputs, check every output mid-cycle, advance the model.
    task automatic step(input bit p, input logic [DW-1:0] d, input bit r,
                        input bit c = 1'b0, input bit rs = 1'b1);
        int            n;
        bit            wr_ok;
        bit            rd_ok;
        logic [DW-1:0] head;
        n     = q.size();
        wr_ok = p && (n < DEPTH);
        rd_ok = r && (n > 0);
        head  = (n > 0) ? q[0] : '0;
        drive(p, d, r, c, rs);
        @(negedge clk);
        check("fill0",   32'(bus0.fill_level),   32'(n));
        check("fill1",   32'(bus1.fill_level),   32'(n));
        check("full0",   32'(bus0.full),         32'(n == DEPTH));
        check("full1",   32'(bus1.full),         32'(n == DEPTH));
        check("empty0",  32'(bus0.empty),        32'(n == 0));
        check("empty1",  32'(bus1.empty),        32'(n == 0));
        check("afull0",  32'(bus0.almost_full),  32'(n >= AF));
        check("aempty0", 32'(bus0.almost_empty), 32'(n <= AE));
        check("ovf0",    32'(bus0.overflow),     32'(m_ov));
        check("ovf1",    32'(bus1.overflow),     32'(m_ov));
        check("udf0",    32'(bus0.underflow),    32'(m_uf));
        check("udf1",    32'(bus1.underflow),    32'(m_uf));
        check("dout0",   32'(bus0.data_out),     (rs && rd_ok) ? 32'(head) : 32'h0);
        check("dval0",   32'(bus0.data_valid),   32'(rs && rd_ok));
        check("dout1",   32'(bus1.data_out),     32'(m_l1_data));
        check("dval1",   32'(bus1.data_valid),   32'(m_l1_valid));
        @(posedge clk);
        if (!rs) begin
            q.delete();
            m_ov       = 1'b0;
            m_uf       = 1'b0;
            m_l1_data  = '0;
            m_l1_valid = 1'b0;
        end else begin
            m_l1_data  = rd_ok ? head : '0;
            m_l1_valid = rd_ok;
            m_ov       = (p && n == DEPTH) || (m_ov && !c);
            m_uf       = (r && n == 0)     || (m_uf && !c);
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
        end
        #1;
    endtask

    initial begin
        logic [DW-1:0] pat;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        q.delete();
        m_ov = 1'b0; m_uf = 1'b0; m_l1_data = '0; m_l1_valid = 1'b0;

        // Reset state, then fill 0x001..0x008 and push once more while full.
        step(1'b0, '0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) step(1'b1, DW'(i), 1'b0);
        step(1'b1, 10'h3FF, 1'b0);
        step(1'b0, '0, 1'b0);

        // Drain in order, then clear the sticky overflow.
        for (int i = 0; i < DEPTH; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b0);

        // Pop on empty, then push+pop together on empty.
        step(1'b0, '0, 1'b1);
        step(1'b1, 10'h155, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Full with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < DEPTH; i++) step(1'b1, DW'(10'h100 + i), 1'b0);
        pat = 10'h200;
        for (int i = 0; i < 20; i++) begin
            step(1'b1, pat, 1'b1);
            pat = pat + 10'd1;
        end
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Registered-port pulse pattern.
        step(1'b1, 10'h0AA, 1'b0);
        step(1'b1, 10'h055, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0);

        // Reset mid-stream during a pop, then pop on the now-empty FIFO.
        for (int i = 0; i < 5; i++) step(1'b1, DW'(10'h030 + i), 1'b0);
        step(1'b1, 10'h3FF, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b0, 1'b1);

        // Random traffic in fill-biased, drain-biased and balanced phases.
        for (int phase = 0; phase < 3; phase++) begin
            for (int i = 0; i < 150; i++) begin
                int pp;
                int pr;
                pp = (phase == 0) ? 80 : (phase == 1) ? 25 : 50;
                pr = (phase == 0) ? 25 : (phase == 1) ? 80 : 50;
                step($urandom_range(99) < pp, DW'($urandom), $urandom_range(99) < pr,
                     $urandom_range(99) < 6, $urandom_range(99) >= 2);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
